// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the fetch-stage branch target predictor:
// predictor mode encodings and the saturating-counter operation codes.
package branch_target_predictor_pkg;

   localparam int BP_STATIC_NT = 0;
   localparam int BP_BTB       = 1;
   localparam int BP_BIMODAL   = 2;

   typedef enum logic [2:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC,
      CNT_SET_MAX,
      CNT_LOAD_INIT
   } cnt_op_e;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one saturating prediction counter. Increment and
// decrement stop at the rails; set-max marks a jump as strongly taken and
// load-init gives a freshly allocated branch the weakly-taken value.
module bp_sat_counter
   import branch_target_predictor_pkg::*;
#(
   parameter int CNT_BITS = 2
) (
   input  cnt_op_e             op_i,
   input  logic [CNT_BITS-1:0] cnt_i,
   output logic [CNT_BITS-1:0] cnt_o
);

   localparam logic [CNT_BITS-1:0] CntMax  = '1;
   localparam logic [CNT_BITS-1:0] CntInit = CNT_BITS'(1) << (CNT_BITS - 1);

   // Pick the counter's next value from the requested operation, holding
   // at the top or bottom instead of wrapping around.
   always_comb begin
      cnt_o = cnt_i;
      unique case (op_i)
         CNT_INC: begin
            if (cnt_i != CntMax) begin
               cnt_o = cnt_i + CNT_BITS'(1);
            end
         end
         CNT_DEC: begin
            if (cnt_i != '0) begin
               cnt_o = cnt_i - CNT_BITS'(1);
            end
         end
         CNT_SET_MAX:   cnt_o = CntMax;
         CNT_LOAD_INIT: cnt_o = CntInit;
         default:       cnt_o = cnt_i;
      endcase
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Fetch looks the table up combinationally; the resolution stage feeds back
// one outcome per cycle, which updates the table, raises a flush when the
// carried prediction was wrong, and bumps the branch/mispredict statistics.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int INDEX_BITS = 4,
   parameter int CNT_BITS   = 2,
   parameter int MODE       = BP_BIMODAL
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pc_i,
   output logic                 pred_hit_o,
   output logic                 pred_taken_o,
   output logic [WORD_SIZE-1:0] pred_next_pc_o,
   input  logic                 upd_valid_i,
   input  logic [WORD_SIZE-1:0] upd_pc_i,
   input  logic                 upd_is_ctrl_i,
   input  logic                 upd_is_jump_i,
   input  logic                 upd_taken_i,
   input  logic [WORD_SIZE-1:0] upd_target_i,
   input  logic [WORD_SIZE-1:0] upd_pred_next_pc_i,
   output logic                 flush_o,
   output logic [WORD_SIZE-1:0] redirect_pc_o,
   output logic [WORD_SIZE-1:0] num_ctrl_o,
   output logic [WORD_SIZE-1:0] num_mispred_o
);

   localparam int Entries = 1 << INDEX_BITS;
   localparam int TagBits = WORD_SIZE - INDEX_BITS;
   localparam logic [WORD_SIZE-1:0] StatMax = '1;

   logic                 entryValid_q  [Entries];
   logic [TagBits-1:0]   entryTag_q    [Entries];
   logic [WORD_SIZE-1:0] entryTarget_q [Entries];
   logic [CNT_BITS-1:0]  entryCnt_q    [Entries];

   logic [INDEX_BITS-1:0] lookupIdx;
   logic [TagBits-1:0]    lookupTag;
   logic                  lookupHit;
   logic                  lookupTaken;

   logic [INDEX_BITS-1:0] updIdx;
   logic [TagBits-1:0]    updTag;
   logic                  updHit;
   logic [WORD_SIZE-1:0]  actualNext;
   logic                  flushInt;

   logic                 writeEn;
   logic                 writeValid_d;
   logic [TagBits-1:0]   writeTag_d;
   logic [WORD_SIZE-1:0] writeTarget_d;
   logic [CNT_BITS-1:0]  writeCnt_d;
   cnt_op_e              cntOp;

   logic [WORD_SIZE-1:0] numCtrl_q;
   logic [WORD_SIZE-1:0] numCtrl_d;
   logic [WORD_SIZE-1:0] numMispred_q;
   logic [WORD_SIZE-1:0] numMispred_d;

   assign lookupIdx = pc_i[INDEX_BITS-1:0];
   assign lookupTag = pc_i[WORD_SIZE-1:INDEX_BITS];
   assign updIdx    = upd_pc_i[INDEX_BITS-1:0];
   assign updTag    = upd_pc_i[WORD_SIZE-1:INDEX_BITS];

   // Fetch-side lookup: a hit needs a valid entry with a matching tag, and
   // the taken decision depends on the predictor flavour. Reset holds the
   // prediction at fall-through regardless of what the flops contain.
   always_comb begin
      lookupHit   = reset_n & entryValid_q[lookupIdx] & (entryTag_q[lookupIdx] == lookupTag);
      lookupTaken = 1'b0;
      if (MODE == BP_BTB) begin
         lookupTaken = lookupHit;
      end else if (MODE == BP_BIMODAL) begin
         lookupTaken = lookupHit & entryCnt_q[lookupIdx][CNT_BITS-1];
      end
   end

   assign pred_hit_o     = lookupHit;
   assign pred_taken_o   = lookupTaken;
   assign pred_next_pc_o = lookupTaken ? entryTarget_q[lookupIdx] : pc_i + WORD_SIZE'(1);

   // Resolution side: work out where the instruction really went and flag a
   // redirect whenever that differs from the PC fetch guessed for it.
   always_comb begin
      updHit     = entryValid_q[updIdx] & (entryTag_q[updIdx] == updTag);
      actualNext = (upd_taken_i | upd_is_jump_i) ? upd_target_i : upd_pc_i + WORD_SIZE'(1);
      flushInt   = reset_n & upd_valid_i & (actualNext != upd_pred_next_pc_i);
   end

   assign flush_o       = flushInt;
   assign redirect_pc_o = actualNext;

   // Decide how the entry at the resolved index changes. Jumps always
   // (re)claim their slot as strongly taken, known branches train their
   // counter, new taken branches evict whatever aliased there, and a
   // non-branch that hits drops the stale entry so it stops predicting.
   always_comb begin
      writeEn       = 1'b0;
      writeValid_d  = entryValid_q[updIdx];
      writeTag_d    = entryTag_q[updIdx];
      writeTarget_d = entryTarget_q[updIdx];
      cntOp         = CNT_HOLD;
      if (upd_valid_i && (MODE != BP_STATIC_NT)) begin
         if (upd_is_ctrl_i) begin
            if (upd_is_jump_i) begin
               writeEn       = 1'b1;
               writeValid_d  = 1'b1;
               writeTag_d    = updTag;
               writeTarget_d = upd_target_i;
               cntOp         = CNT_SET_MAX;
            end else if (updHit) begin
               writeEn = 1'b1;
               if (upd_taken_i) begin
                  writeTarget_d = upd_target_i;
                  cntOp         = CNT_INC;
               end else begin
                  cntOp = CNT_DEC;
               end
            end else if (upd_taken_i) begin
               writeEn       = 1'b1;
               writeValid_d  = 1'b1;
               writeTag_d    = updTag;
               writeTarget_d = upd_target_i;
               cntOp         = CNT_LOAD_INIT;
            end
         end else if (updHit) begin
            writeEn      = 1'b1;
            writeValid_d = 1'b0;
         end
      end
   end

   bp_sat_counter #(
      .CNT_BITS(CNT_BITS)
   ) uSatCnt (
      .op_i (cntOp),
      .cnt_i(entryCnt_q[updIdx]),
      .cnt_o(writeCnt_d)
   );

   // Table storage lives in flops so the whole BTB can be cleared by the
   // asynchronous reset; only the single resolved entry is written per cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < Entries; i++) begin
            entryValid_q[i]  <= 1'b0;
            entryTag_q[i]    <= '0;
            entryTarget_q[i] <= '0;
            entryCnt_q[i]    <= '0;
         end
      end else if (writeEn) begin
         entryValid_q[updIdx]  <= writeValid_d;
         entryTag_q[updIdx]    <= writeTag_d;
         entryTarget_q[updIdx] <= writeTarget_d;
         entryCnt_q[updIdx]    <= writeCnt_d;
      end
   end

   // Statistics counters stick at all-ones rather than wrapping, so a long
   // run never reports a misleadingly small number.
   always_comb begin
      numCtrl_d    = numCtrl_q;
      numMispred_d = numMispred_q;
      if (upd_valid_i && upd_is_ctrl_i && (numCtrl_q != StatMax)) begin
         numCtrl_d = numCtrl_q + WORD_SIZE'(1);
      end
      if (flushInt && (numMispred_q != StatMax)) begin
         numMispred_d = numMispred_q + WORD_SIZE'(1);
      end
   end

   // Register the statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         numCtrl_q    <= '0;
         numMispred_q <= '0;
      end else begin
         numCtrl_q    <= numCtrl_d;
         numMispred_q <= numMispred_d;
      end
   end

   assign num_ctrl_o    = numCtrl_q;
   assign num_mispred_o = numMispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: three 16-bit instances (bimodal,
// BTB-hit-taken, static not-taken) share one stimulus stream and are checked
// against a behavioural table model; a 4-bit instance covers stat saturation.
module tb_branch_target_predictor;
   import branch_target_predictor_pkg::*;

   localparam int W       = 16;
   localparam int NumInst = 3;
   localparam int SW      = 4;

   typedef enum int {
      SIG_HIT, SIG_TAKEN, SIG_NEXT, SIG_FLUSH, SIG_REDIRECT, SIG_NCTRL, SIG_NMISPRED,
      SIG_D_HIT, SIG_D_NEXT, SIG_D_FLUSH, SIG_D_NCTRL, SIG_D_NMISPRED
   } sig_e;

   typedef struct {
      sig_e         sig;
      int           inst;
      logic [W-1:0] value;
   } exp_t;

   typedef struct {
      logic         valid;
      logic         ctrl;
      logic         jump;
      logic         taken;
      logic [W-1:0] pc;
      logic [W-1:0] target;
      logic [W-1:0] predNext;
   } upd_t;

   logic clk = 1'b0;
   logic reset_n;

   logic [W-1:0] pc;
   logic         updValid;
   logic [W-1:0] updPc;
   logic         updIsCtrl;
   logic         updIsJump;
   logic         updTaken;
   logic [W-1:0] updTarget;
   logic [W-1:0] updPredNext;

   logic         predHit    [NumInst];
   logic         predTaken  [NumInst];
   logic [W-1:0] predNext   [NumInst];
   logic         flush      [NumInst];
   logic [W-1:0] redirect   [NumInst];
   logic [W-1:0] numCtrl    [NumInst];
   logic [W-1:0] numMispred [NumInst];

   logic [SW-1:0] dPc;
   logic          dUpdValid;
   logic [SW-1:0] dUpdPc;
   logic          dUpdIsCtrl;
   logic          dUpdIsJump;
   logic          dUpdTaken;
   logic [SW-1:0] dUpdTarget;
   logic [SW-1:0] dUpdPredNext;
   logic          dPredHit;
   logic          dPredTaken;
   logic [SW-1:0] dPredNext;
   logic          dFlush;
   logic [SW-1:0] dRedirect;
   logic [SW-1:0] dNumCtrl;
   logic [SW-1:0] dNumMispred;

   logic         mdlValid  [NumInst][16];
   logic [11:0]  mdlTag    [NumInst][16];
   logic [W-1:0] mdlTarget [NumInst][16];
   logic [1:0]   mdlCnt    [NumInst][16];
   int           mdlCtrl   [NumInst];
   int           mdlMis    [NumInst];

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NumInst; g++) begin : gDut
      branch_target_predictor #(
         .WORD_SIZE (W),
         .INDEX_BITS(4),
         .CNT_BITS  (2),
         .MODE      (2 - g)
      ) uDut (
         .clk               (clk),
         .reset_n           (reset_n),
         .pc_i              (pc),
         .pred_hit_o        (predHit[g]),
         .pred_taken_o      (predTaken[g]),
         .pred_next_pc_o    (predNext[g]),
         .upd_valid_i       (updValid),
         .upd_pc_i          (updPc),
         .upd_is_ctrl_i     (updIsCtrl),
         .upd_is_jump_i     (updIsJump),
         .upd_taken_i       (updTaken),
         .upd_target_i      (updTarget),
         .upd_pred_next_pc_i(updPredNext),
         .flush_o           (flush[g]),
         .redirect_pc_o     (redirect[g]),
         .num_ctrl_o        (numCtrl[g]),
         .num_mispred_o     (numMispred[g])
      );
   end

   branch_target_predictor #(
      .WORD_SIZE (SW),
      .INDEX_BITS(2),
      .CNT_BITS  (2),
      .MODE      (BP_BIMODAL)
   ) uDutSmall (
      .clk               (clk),
      .reset_n           (reset_n),
      .pc_i              (dPc),
      .pred_hit_o        (dPredHit),
      .pred_taken_o      (dPredTaken),
      .pred_next_pc_o    (dPredNext),
      .upd_valid_i       (dUpdValid),
      .upd_pc_i          (dUpdPc),
      .upd_is_ctrl_i     (dUpdIsCtrl),
      .upd_is_jump_i     (dUpdIsJump),
      .upd_taken_i       (dUpdTaken),
      .upd_target_i      (dUpdTarget),
      .upd_pred_next_pc_i(dUpdPredNext),
      .flush_o           (dFlush),
      .redirect_pc_o     (dRedirect),
      .num_ctrl_o        (dNumCtrl),
      .num_mispred_o     (dNumMispred)
   );

   // Instance g was built with MODE = 2 - g.
   function automatic int modeOf(input int m);
      return 2 - m;
   endfunction

   function automatic logic [W-1:0] actualNextOf(input upd_t u);
      if (u.taken || u.jump) return u.target;
      return u.pc + 16'd1;
   endfunction

   function automatic upd_t noUpd();
      upd_t u;
      u.valid = 1'b0; u.ctrl = 1'b0; u.jump = 1'b0; u.taken = 1'b0;
      u.pc = '0; u.target = '0; u.predNext = '0;
      return u;
   endfunction

   function automatic upd_t mkUpd(input logic ctrl, input logic jump, input logic taken,
                                  input logic [W-1:0] upc, input logic [W-1:0] target,
                                  input logic [W-1:0] predNextIn);
      upd_t u;
      u.valid = 1'b1; u.ctrl = ctrl; u.jump = jump; u.taken = taken;
      u.pc = upc; u.target = target; u.predNext = predNextIn;
      return u;
   endfunction

   // Reference table: cleared on reset.
   task automatic mdlReset();
      for (int m = 0; m < NumInst; m++) begin
         for (int i = 0; i < 16; i++) begin
            mdlValid[m][i]  = 1'b0;
            mdlTag[m][i]    = '0;
            mdlTarget[m][i] = '0;
            mdlCnt[m][i]    = '0;
         end
         mdlCtrl[m] = 0;
         mdlMis[m]  = 0;
      end
   endtask

   // Reference lookup for instance m.
   task automatic mdlLookup(input int m, input logic [W-1:0] p, output logic h,
                            output logic t, output logic [W-1:0] n);
      logic [3:0] i;
      i = p[3:0];
      h = mdlValid[m][i] && (mdlTag[m][i] == p[15:4]);
      case (modeOf(m))
         BP_STATIC_NT: t = 1'b0;
         BP_BTB:       t = h;
         default:      t = h && mdlCnt[m][i][1];
      endcase
      n = t ? mdlTarget[m][i] : p + 16'd1;
   endtask

   // Reference table and statistics update, applied once per clock edge.
   task automatic mdlUpdate(input int m, input upd_t u);
      logic [3:0]   i;
      logic [11:0]  tg;
      logic         hitU;
      if (!u.valid) return;
      if (u.ctrl && mdlCtrl[m] < 65535) mdlCtrl[m]++;
      if ((actualNextOf(u) != u.predNext) && mdlMis[m] < 65535) mdlMis[m]++;
      if (modeOf(m) == BP_STATIC_NT) return;
      i    = u.pc[3:0];
      tg   = u.pc[15:4];
      hitU = mdlValid[m][i] && (mdlTag[m][i] == tg);
      if (u.ctrl) begin
         if (u.jump) begin
            mdlValid[m][i] = 1'b1; mdlTag[m][i] = tg; mdlTarget[m][i] = u.target; mdlCnt[m][i] = 2'b11;
         end else if (hitU && u.taken) begin
            if (mdlCnt[m][i] != 2'b11) mdlCnt[m][i] = mdlCnt[m][i] + 2'd1;
            mdlTarget[m][i] = u.target;
         end else if (hitU) begin
            if (mdlCnt[m][i] != 2'b00) mdlCnt[m][i] = mdlCnt[m][i] - 2'd1;
         end else if (u.taken) begin
            mdlValid[m][i] = 1'b1; mdlTag[m][i] = tg; mdlTarget[m][i] = u.target; mdlCnt[m][i] = 2'b10;
         end
      end else if (hitU) begin
         mdlValid[m][i] = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input sig_e s, input int inst, input logic [W-1:0] v);
      exp_t e;
      e.sig = s; e.inst = inst; e.value = v;
      expQ.push_back(e);
   endtask

   // Pop every pending expectation and compare it with the matching output.
   task automatic drainScoreboard();
      exp_t         e;
      logic [W-1:0] obs;
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         case (e.sig)
            SIG_HIT:        obs = {15'd0, predHit[e.inst]};
            SIG_TAKEN:      obs = {15'd0, predTaken[e.inst]};
            SIG_NEXT:       obs = predNext[e.inst];
            SIG_FLUSH:      obs = {15'd0, flush[e.inst]};
            SIG_REDIRECT:   obs = redirect[e.inst];
            SIG_NCTRL:      obs = numCtrl[e.inst];
            SIG_NMISPRED:   obs = numMispred[e.inst];
            SIG_D_HIT:      obs = {15'd0, dPredHit};
            SIG_D_NEXT:     obs = {12'd0, dPredNext};
            SIG_D_FLUSH:    obs = {15'd0, dFlush};
            SIG_D_NCTRL:    obs = {12'd0, dNumCtrl};
            SIG_D_NMISPRED: obs = {12'd0, dNumMispred};
            default:        obs = 'x;
         endcase
         checkOutput($sformatf("%s[%0d]", e.sig.name(), e.inst), obs, e.value);
      end
   endtask

   // One cycle on the 16-bit instances: drive at the falling edge, queue the
   // model's expectations, compare shortly after, then advance the model to
   // what the next rising edge will do.
   task automatic applyStimulus(input logic rstN, input logic [W-1:0] lookupPc, input upd_t u);
      logic         h;
      logic         t;
      logic [W-1:0] n;
      logic         f;
      @(negedge clk);
      reset_n     = rstN;
      pc          = lookupPc;
      updValid    = u.valid;
      updPc       = u.pc;
      updIsCtrl   = u.ctrl;
      updIsJump   = u.jump;
      updTaken    = u.taken;
      updTarget   = u.target;
      updPredNext = u.predNext;
      if (!rstN) mdlReset();
      for (int m = 0; m < NumInst; m++) begin
         mdlLookup(m, lookupPc, h, t, n);
         pushExp(SIG_HIT, m, {15'd0, h});
         pushExp(SIG_TAKEN, m, {15'd0, t});
         pushExp(SIG_NEXT, m, n);
         f = rstN && u.valid && (actualNextOf(u) != u.predNext);
         pushExp(SIG_FLUSH, m, {15'd0, f});
         if (f) pushExp(SIG_REDIRECT, m, actualNextOf(u));
         pushExp(SIG_NCTRL, m, W'(mdlCtrl[m]));
         pushExp(SIG_NMISPRED, m, W'(mdlMis[m]));
      end
      #2;
      drainScoreboard();
      if (rstN) begin
         for (int m = 0; m < NumInst; m++) mdlUpdate(m, u);
      end
   endtask

   function automatic logic [W-1:0] randPc();
      if ($urandom_range(0, 9) == 0) return 16'hFFFF;
      return (W'($urandom_range(0, 2)) << 4) | W'($urandom_range(0, 3));
   endfunction

   initial begin
      reset_n = 1'b0;
      pc = '0; updValid = 1'b0; updPc = '0; updIsCtrl = 1'b0; updIsJump = 1'b0;
      updTaken = 1'b0; updTarget = '0; updPredNext = '0;
      dPc = 4'hF; dUpdValid = 1'b0; dUpdPc = '0; dUpdIsCtrl = 1'b0; dUpdIsJump = 1'b0;
      dUpdTaken = 1'b0; dUpdTarget = '0; dUpdPredNext = '0;
      mdlReset();

      // Reset state, then first taken branch mispredicts and allocates.
      applyStimulus(1'b0, 16'h0010, noUpd());
      applyStimulus(1'b0, 16'h0010, noUpd());
      applyStimulus(1'b1, 16'h0010, mkUpd(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0040, 16'h0011));
      applyStimulus(1'b1, 16'h0010, noUpd());

      // Train the branch not-taken twice; bimodal falls back to fall-through.
      applyStimulus(1'b1, 16'h0010, mkUpd(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0040, 16'h0040));
      applyStimulus(1'b1, 16'h0010, mkUpd(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0040, 16'h0040));
      applyStimulus(1'b1, 16'h0010, noUpd());

      // Non-branch hit removes the alias; a taken branch at 0x0020 takes the slot.
      applyStimulus(1'b1, 16'h0010, mkUpd(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0011));
      applyStimulus(1'b1, 16'h0010, mkUpd(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0080, 16'h0021));
      applyStimulus(1'b1, 16'h0020, noUpd());
      applyStimulus(1'b1, 16'h0010, noUpd());

      // Jump at the top of the address space, and fall-through wrap to zero.
      applyStimulus(1'b1, 16'hFFFF, mkUpd(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0003, 16'h0000));
      applyStimulus(1'b1, 16'hFFFF, noUpd());

      // Same-cycle lookup and update of one index sees the old contents.
      applyStimulus(1'b1, 16'h0020, mkUpd(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0021));
      applyStimulus(1'b1, 16'h0020, noUpd());

      // Mixed random traffic over a few aliasing addresses.
      for (int k = 0; k < 300; k++) begin
         upd_t         u;
         logic         h;
         logic         t;
         logic [W-1:0] n;
         u.valid  = ($urandom_range(0, 3) != 0);
         u.ctrl   = ($urandom_range(0, 3) != 0);
         u.jump   = u.ctrl && ($urandom_range(0, 7) == 0);
         u.taken  = ($urandom_range(0, 1) == 1);
         u.pc     = randPc();
         u.target = W'($urandom_range(1, 8)) << 5;
         case ($urandom_range(0, 2))
            0: begin
               mdlLookup(0, u.pc, h, t, n);
               u.predNext = n;
            end
            1:       u.predNext = u.pc + 16'd1;
            default: u.predNext = u.target;
         endcase
         applyStimulus(1'b1, randPc(), u);
      end

      // Set up known entries, then reset in the middle of a mispredicting update.
      applyStimulus(1'b1, 16'h0020, mkUpd(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0200, 16'h0021));
      applyStimulus(1'b1, 16'h0020, mkUpd(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0003, 16'h0000));
      applyStimulus(1'b0, 16'h0020, mkUpd(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0300, 16'h0021));
      applyStimulus(1'b1, 16'h0020, noUpd());
      applyStimulus(1'b1, 16'hFFFF, noUpd());

      // Narrow instance: drive more mispredicts than the counter can hold.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         dPc          = 4'hF;
         dUpdValid    = 1'b1;
         dUpdIsCtrl   = 1'b1;
         dUpdIsJump   = 1'b0;
         dUpdTaken    = 1'b0;
         dUpdPc       = 4'h0;
         dUpdTarget   = 4'h8;
         dUpdPredNext = 4'h5;
         pushExp(SIG_D_HIT, 0, 16'd0);
         pushExp(SIG_D_NEXT, 0, 16'd0);
         pushExp(SIG_D_FLUSH, 0, 16'd1);
         pushExp(SIG_D_NCTRL, 0, (k > 15) ? 16'd15 : W'(k));
         pushExp(SIG_D_NMISPRED, 0, (k > 15) ? 16'd15 : W'(k));
         #2;
         drainScoreboard();
      end
      @(negedge clk);
      dUpdValid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
